imm_gen_pipe: RTL

Pipelined immediate generator for the decode stage. It extends the current two-format (I/S) sign extender to every RV32 immediate format plus the zero-extended shamt and CSR-zimm fields, and generalises the output to `DATA_WIDTH`. A registered valid/ready stage with a two-entry skid buffer sits between fetch/decode and the ID/EX register. It also carries a caller-defined tag (PC, rd, etc.) alongside each immediate.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_decode.sv | 36 +++
 rtl/imm_gen_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format selects and reference instruction words
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_ZIMM  = 3'd6,
        IMM_ILL   = 3'd7
    } imm_src_e;

    // Reference encodings exercising each immediate format
    localparam logic [31:0] INSTR_ADDI_M1    = 32'hFFF00093;
    localparam logic [31:0] INSTR_SW_M4      = 32'hFE20AE23;
    localparam logic [31:0] INSTR_BEQ_M8     = 32'hFE000CE3;
    localparam logic [31:0] INSTR_LUI_12345  = 32'h123450B7;
    localparam logic [31:0] INSTR_JAL_800    = 32'h001000EF;
    localparam logic [31:0] INSTR_SLLI_31    = 32'h01F09093;
    localparam logic [31:0] INSTR_CSRRWI_31  = 32'h000FD073;
    localparam logic [31:0] INSTR_LUI_NEG    = 32'h800000B7;
    localparam logic [31:0] INSTR_ADDI_7FF   = 32'h7FF00093;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32 immediate extraction and extension
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  logic [IMM_SRC_W-1:0]  imm_src,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  err
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = &{1'b0, instr[6:0]};

    // Zero-extended formats leave bit 31 clear, so one sign extension covers all
    always_comb begin
        imm32 = 32'd0;
        err   = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm32 = {instr[31:12], 12'd0};
            IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'd0, instr[24:20]};
            IMM_ZIMM:  imm32 = {27'd0, instr[19:15]};
            default:   err   = 1'b1;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator stage with two-entry skid buffer
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [2:0]            imm_src,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm_op,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  imm_err
);

    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_err;

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_imm;
    logic [TAG_WIDTH-1:0]  main_tag;
    logic                  main_err;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_imm;
    logic [TAG_WIDTH-1:0]  skid_tag;
    logic                  skid_err;

    logic                  accept;
    logic                  consume;

    imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .err     (dec_err)
    );

    // in_ready depends only on stored state, never on out_ready
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready && !flush;
    assign consume   = main_valid && out_ready;

    assign out_valid = main_valid;
    assign imm_op    = main_imm;
    assign out_tag   = main_tag;
    assign imm_err   = main_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume || !main_valid) begin
            // Main slot is free this edge: refill from skid first to keep FIFO order
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_tag   <= skid_tag;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_imm   <= dec_imm;
                main_tag   <= in_tag;
                main_err   <= dec_err;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_tag   <= in_tag;
            skid_err   <= dec_err;
        end
    end

endmodule
